vgafb_pixelfeed: RTL and testbench
==================================

Name: vgafb_pixelfeed

Overview:
- Frame-buffer fetch stage between the VGA framebuffer control registers and the scan-out FIFO/timing logic.
- Issues 4-beat 64-bit FML read bursts starting at the programmed frame base address.
- Buffers the returned words and serialises each 64-bit word into four RGB565 pixels behind a valid/ack stream.
- Acknowledges adoption of a new base address once per frame.

Parameters:
- fifo_depth_log2, 4, log2 of internal FIFO depth in 64-bit words (default 16 words); minimum 3.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- vga_rst  in  1  soft reset from control registers; synchronous, active-high
- baseaddress  in  32  frame start byte address
- baseaddress_ack  out  1  one-cycle pulse when baseaddress is latched for a new frame
- nbursts  in  19  bursts per frame
- fml_adr  out  32  burst byte address; bits[4:0] always 0
- fml_stb  out  1  burst request strobe
- fml_ack  in  1  slave accept; coincides with first data beat
- fml_di  in  64  read data
- pixel  out  16  RGB565 pixel
- pixel_valid  out  1  pixel holds valid data
- pixel_ack  in  1  consumer pop

Behaviour:
- Reset (sys_rst_n low, asynchronous) values:
  - fml_stb=0, fml_adr=0, baseaddress_ack=0, pixel_valid=0, pixel=0.
  - FIFO empty; burst counter=0; state IDLE; frame_start flag=1.
- FSM states:
  - IDLE -> REQ when vga_rst=0, nbursts!=0, and FIFO free space (depth minus stored words minus words reserved) >= 4.
    - On entry from a frame start: latch baseaddress with bits[4:0] cleared into fml_adr, pulse baseaddress_ack for that one cycle, clear burst counter.
    - Otherwise fml_adr is the previous burst address + 32.
    - Entry reserves 4 FIFO words.
  - REQ: fml_stb=1 and fml_adr held stable until fml_ack.
    - On the fml_ack cycle: fml_stb drops the next cycle, beat 0 is written, and the FSM moves to DATA.
  - DATA: exactly 3 further beats, one per cycle, with no ack required. After beat 3 -> IDLE.
    - Burst counter increments.
    - If counter == nbursts-1 before the increment, set frame_start (next burst restarts at baseaddress).
- Timing: at most one burst is outstanding. Minimum IDLE->REQ latency is 1 cycle after the space condition is met.
- Counter and address arithmetic:
  - Burst counter is 19 bits.
  - fml_adr increments by 32 modulo 2^32; wrap-around is silent.
  - nbursts changes take effect at the next comparison.
- Output serialiser (this is the scan-out path; first-word fall-through):
  - Pops one FIFO word into a 64-bit shift register. pixel = bits[63:48] first, then [47:32], [31:16], [15:0].
  - A pixel transfers when pixel_valid & pixel_ack. The next pixel is presented the following cycle with no bubble while data is available.
  - pixel_valid=0 when the shift register is exhausted and the FIFO is empty.
  - pixel_ack with pixel_valid=0 is ignored.
- Simultaneous FIFO write and read is allowed at any occupancy. Full is impossible by construction because of the reservation.
- vga_rst=1:
  - In IDLE: flush FIFO and serialiser, clear reservations, set frame_start, pixel_valid=0 next cycle, no new request.
  - In REQ/DATA: the burst runs to completion on the bus (stb held until ack, 3 beats consumed), data is discarded, then the flush happens.
  - vga_rst=0 with frame_start set restarts from baseaddress.
- nbursts=0: never requests; pixel_valid stays 0.

Optional Feature:
- Macro: VGAFB_UNDERFLOW_CNT_EN.
- With the macro defined:
  - Adds output underflow_cnt (16 bits).
  - Increments when pixel_ack=1 and pixel_valid=0, saturating at 16'hFFFF.
  - Cleared by sys_rst_n low or vga_rst=1.
- Without it: the port and logic are absent; underflow is silently ignored.

Test Plan:
- Frame fetch: baseaddress=32'h4000_0010, nbursts=2, slave acks after 2 cycles -> baseaddress_ack pulses once; fml_adr=32'h4000_0000 then 32'h4000_0020; third burst returns to 32'h4000_0000 with a second ack pulse.
- Pixel order: beat 64'h1111_2222_3333_4444 with pixel_ack held high -> pixels 1111, 2222, 3333, 4444 on 4 consecutive cycles.
- Back-pressure: pixel_ack=0 for 200 cycles, fifo_depth_log2=4 -> exactly 4 bursts issued, then fml_stb stays 0; releasing pixel_ack resumes requests after 4 words are drained.
- Mid-burst soft reset: assert vga_rst during beat 1 -> remaining beats consumed, pixel_valid=0, no request while vga_rst=1; deassert -> next fml_adr equals baseaddress with baseaddress_ack pulse.
- Async reset during REQ: sys_rst_n low for 1 cycle mid-stb -> fml_stb, pixel_valid, baseaddress_ack are 0 immediately, without waiting for a clock edge.
- With VGAFB_UNDERFLOW_CNT_EN: nbursts=0, pixel_ack high for 10 cycles -> underflow_cnt=10; then vga_rst pulse -> 0.

Source files
------------

// File: rtl/vgafb_pixelfeed.sv
// Framebuffer fetch stage: 4-beat FML bursts into a word FIFO, serialised to RGB565 pixels.
// Optional underflow counter is enabled by defining VGAFB_UNDERFLOW_CNT_EN.
//
// state | meaning
// IDLE  | waiting for FIFO space; vga_rst flushes here
// REQ   | fml_stb high, address held until fml_ack (beat 0)
// DATA  | beats 1..3, one per cycle, no handshake
module vgafb_pixelfeed #(
    parameter int fifo_depth_log2 = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        vga_rst,
    input  logic [31:0] baseaddress,
    output logic        baseaddress_ack,
    input  logic [18:0] nbursts,
    output logic [31:0] fml_adr,
    output logic        fml_stb,
    input  logic        fml_ack,
    input  logic [63:0] fml_di,
    output logic [15:0] pixel,
    output logic        pixel_valid,
`ifdef VGAFB_UNDERFLOW_CNT_EN
    output logic [15:0] underflow_cnt,
`endif
    input  logic        pixel_ack
);

    localparam int L = fifo_depth_log2;
    localparam logic [L:0] DEPTH_W = {1'b1, {L{1'b0}}};
    localparam logic [L:0] BURST_W = (L+1)'(4);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic        bak_q, bak_d;
    logic [18:0] bcnt_q, bcnt_d;
    logic        fs_q, fs_d;
    logic        discard_q, discard_d;
    logic [1:0]  beat_q, beat_d;
    logic        push, flush, pop, load;

    logic [63:0] mem [1<<L];
    logic [L-1:0] wr_q, rd_q;
    logic [L:0]   cnt_q, cnt_d, free_w;

    logic [63:0] sr_q, sr_d;
    logic [2:0]  pcnt_q, pcnt_d;

    // Only one burst is ever in flight and IDLE is only reached once it has landed,
    // so the 4-word reservation is already reflected in cnt_q whenever free_w is used.
    assign free_w = DEPTH_W - cnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            bak_q     <= 1'b0;
            bcnt_q    <= '0;
            fs_q      <= 1'b1;
            discard_q <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            bak_q     <= bak_d;
            bcnt_q    <= bcnt_d;
            fs_q      <= fs_d;
            discard_q <= discard_d;
            beat_q    <= beat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        bak_d     = 1'b0;
        bcnt_d    = bcnt_q;
        fs_d      = fs_q;
        discard_d = discard_q | vga_rst;
        beat_d    = beat_q;
        push      = 1'b0;
        flush     = vga_rst;
        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (!vga_rst && nbursts != 19'd0 && free_w >= BURST_W) begin
                    state_d = REQ;
                    if (fs_q) begin
                        adr_d  = baseaddress & 32'hFFFF_FFE0;
                        bak_d  = 1'b1;
                        bcnt_d = '0;
                        fs_d   = 1'b0;
                    end else begin
                        adr_d = adr_q + 32'd32;
                    end
                end
            end
            REQ: begin
                if (fml_ack) begin
                    push    = ~discard_d;
                    state_d = DATA;
                    beat_d  = 2'd1;
                end
            end
            DATA: begin
                push   = ~discard_d;
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = IDLE;
                    bcnt_d  = bcnt_q + 19'd1;
                    if (bcnt_q == nbursts - 19'd1)
                        fs_d = 1'b1;
                    if (discard_d)
                        flush = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush)
            fs_d = 1'b1;
    end

    assign fml_stb         = (state_q == REQ);
    assign fml_adr         = adr_q;
    assign baseaddress_ack = bak_q;

    always_ff @(posedge sys_clk) begin
        if (push)
            mem[wr_q] <= fml_di;
    end

    assign load  = (pcnt_q == 3'd0) || (pixel_ack && pcnt_q == 3'd1);
    assign pop   = load && (cnt_q != '0);
    assign cnt_d = cnt_q + {{L{1'b0}}, push} - {{L{1'b0}}, pop};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        sr_d   = sr_q;
        pcnt_d = pcnt_q;
        if (flush) begin
            pcnt_d = 3'd0;
        end else if (pop) begin
            sr_d   = mem[rd_q];
            pcnt_d = 3'd4;
        end else if (pixel_valid && pixel_ack) begin
            sr_d   = {sr_q[47:0], 16'h0000};
            pcnt_d = pcnt_q - 3'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sr_q   <= '0;
            pcnt_q <= '0;
        end else begin
            sr_q   <= sr_d;
            pcnt_q <= pcnt_d;
        end
    end

    assign pixel       = sr_q[63:48];
    assign pixel_valid = (pcnt_q != 3'd0);

`ifdef VGAFB_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            ucnt_q <= '0;
        else if (vga_rst)
            ucnt_q <= '0;
        else if (pixel_ack && !pixel_valid && ucnt_q != 16'hFFFF)
            ucnt_q <= ucnt_q + 16'd1;
    end

    assign underflow_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_vgafb_pixelfeed.sv
// Self-checking bench for vgafb_pixelfeed: FML slave model, pixel scoreboard, per-scenario tasks.
module tb_vgafb_pixelfeed;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        vga_rst;
    logic [31:0] baseaddress;
    logic        baseaddress_ack;
    logic [18:0] nbursts;
    logic [31:0] fml_adr;
    logic        fml_stb;
    logic        fml_ack;
    logic [63:0] fml_di;
    logic [15:0] pixel;
    logic        pixel_valid;
    logic        pixel_ack;
`ifdef VGAFB_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    vgafb_pixelfeed #(.fifo_depth_log2(4)) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .vga_rst(vga_rst),
        .baseaddress(baseaddress),
        .baseaddress_ack(baseaddress_ack),
        .nbursts(nbursts),
        .fml_adr(fml_adr),
        .fml_stb(fml_stb),
        .fml_ack(fml_ack),
        .fml_di(fml_di),
        .pixel(pixel),
        .pixel_valid(pixel_valid),
`ifdef VGAFB_UNDERFLOW_CNT_EN
        .underflow_cnt(underflow_cnt),
`endif
        .pixel_ack(pixel_ack)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    logic [31:0] obs_adr[$];
    logic        obs_bak[$];
    logic [63:0] data_q[$];
    int burst_cnt = 0;
    int ack_cycles = 0;
    int slave_lat = 1;
    bit keep = 1'b1;
    logic [15:0] wseq = 16'h0100;

    // FML slave: records each request, waits slave_lat cycles, then returns 4 beats
    initial begin
        logic [63:0] w;
        int waited;
        fml_ack = 1'b0;
        fml_di  = '0;
        forever begin
            @(negedge sys_clk);
            if (fml_stb === 1'b1) begin
                obs_adr.push_back(fml_adr);
                obs_bak.push_back(baseaddress_ack);
                burst_cnt++;
                waited = 0;
                while (waited < slave_lat && fml_stb === 1'b1) begin
                    @(negedge sys_clk);
                    waited++;
                end
                if (fml_stb === 1'b1) begin
                    for (int b = 0; b < 4; b++) begin
                        if (data_q.size() > 0) w = data_q.pop_front();
                        else begin
                            w = {wseq, wseq + 16'd1, wseq + 16'd2, wseq + 16'd3};
                            wseq = wseq + 16'd4;
                        end
                        if (keep) begin
                            exp_q.push_back(w[63:48]);
                            exp_q.push_back(w[47:32]);
                            exp_q.push_back(w[31:16]);
                            exp_q.push_back(w[15:0]);
                        end
                        fml_ack = (b == 0);
                        fml_di  = w;
                        @(negedge sys_clk);
                    end
                    fml_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            if (baseaddress_ack === 1'b1) ack_cycles++;
        end
    end

    task automatic sb_clear();
        exp_q.delete();
        obs_adr.delete();
        obs_bak.delete();
        data_q.delete();
        burst_cnt  = 0;
        ack_cycles = 0;
        keep       = 1'b1;
    endtask

    task automatic quiesce();
        vga_rst   = 1'b1;
        pixel_ack = 1'b0;
        slave_lat = 1;
        repeat (20) @(negedge sys_clk);
        total++;
        if (pixel_valid !== 1'b0) begin
            bad++;
            $display("FAIL quiesce_valid: got %b want 0", pixel_valid);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; vga_rst = 1'b1; pixel_ack = 1'b0;
        nbursts = '0; baseaddress = '0;
        repeat (3) @(negedge sys_clk);
        total++; if (fml_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b want 0", fml_stb); end
        total++; if (fml_adr !== 32'h0) begin bad++; $display("FAIL reset_adr: got %h want 0", fml_adr); end
        total++; if (baseaddress_ack !== 1'b0) begin bad++; $display("FAIL reset_bak: got %b want 0", baseaddress_ack); end
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", pixel_valid); end
        total++; if (pixel !== 16'h0) begin bad++; $display("FAIL reset_pixel: got %h want 0", pixel); end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_frame_fetch();
        logic [15:0] e;
        logic [31:0] ea;
        sb_clear();
        baseaddress = 32'h4000_0010; nbursts = 19'd2; slave_lat = 2;
        pixel_ack = 1'b1; vga_rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge sys_clk);
            if (pixel_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL fetch_pixel: got %h want nothing queued", pixel);
                end else begin
                    e = exp_q.pop_front();
                    if (pixel !== e) begin bad++; $display("FAIL fetch_pixel: got %h want %h", pixel, e); end
                end
            end
        end
        quiesce();
        total++;
        if (obs_adr.size() < 3) begin
            bad++; $display("FAIL fetch_bursts: got %0d want >=3", obs_adr.size());
        end
        for (int i = 0; i < obs_adr.size(); i++) begin
            ea = (i % 2 == 0) ? 32'h4000_0000 : 32'h4000_0020;
            total++;
            if (obs_adr[i] !== ea) begin bad++; $display("FAIL fetch_adr[%0d]: got %h want %h", i, obs_adr[i], ea); end
            total++;
            if (obs_bak[i] !== (i % 2 == 0)) begin bad++; $display("FAIL fetch_bak[%0d]: got %b want %b", i, obs_bak[i], (i % 2 == 0)); end
        end
        total++;
        if (ack_cycles != (obs_adr.size() + 1) / 2) begin
            bad++; $display("FAIL fetch_ack_pulses: got %0d want %0d", ack_cycles, (obs_adr.size() + 1) / 2);
        end
    endtask

    task automatic test_pixel_order();
        logic [15:0] order [4];
        logic [15:0] e;
        bit found;
        order[0] = 16'h1111; order[1] = 16'h2222; order[2] = 16'h3333; order[3] = 16'h4444;
        sb_clear();
        data_q.push_back(64'h1111_2222_3333_4444);
        baseaddress = 32'h0; nbursts = 19'd1; slave_lat = 1;
        pixel_ack = 1'b1; vga_rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge sys_clk);
            if (pixel_valid === 1'b1) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL order_timeout: got no pixel_valid want pixel within 50 cycles");
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (pixel_valid !== 1'b1 || pixel !== order[k]) begin
                    bad++; $display("FAIL order_pixel%0d: got v=%b %h want v=1 %h", k, pixel_valid, pixel, order[k]);
                end
                if (exp_q.size() > 0) e = exp_q.pop_front();
                @(negedge sys_clk);
            end
            for (int i = 0; i < 40; i++) begin
                if (pixel_valid === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++; $display("FAIL order_stream: got %h want nothing queued", pixel);
                    end else begin
                        e = exp_q.pop_front();
                        if (pixel !== e) begin bad++; $display("FAIL order_stream: got %h want %h", pixel, e); end
                    end
                end
                @(negedge sys_clk);
            end
        end
        quiesce();
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        int vcnt;
        sb_clear();
        baseaddress = 32'h0000_1000; nbursts = 19'd100; slave_lat = 1;
        pixel_ack = 1'b0; vga_rst = 1'b0;
        repeat (200) @(negedge sys_clk);
        total++;
        if (burst_cnt != 4) begin bad++; $display("FAIL bp_bursts: got %0d want 4", burst_cnt); end
        total++;
        if (fml_stb !== 1'b0) begin bad++; $display("FAIL bp_stb_idle: got %b want 0", fml_stb); end
        pixel_ack = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 214; i++) begin
            if (pixel_valid === 1'b1) begin
                if (i < 64) vcnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_pixel: got %h want nothing queued", pixel);
                end else begin
                    e = exp_q.pop_front();
                    if (pixel !== e) begin bad++; $display("FAIL bp_pixel: got %h want %h", pixel, e); end
                end
            end
            @(negedge sys_clk);
        end
        quiesce();
        total++;
        if (vcnt != 64) begin bad++; $display("FAIL bp_no_bubble: got %0d valid want 64", vcnt); end
        total++;
        if (burst_cnt <= 4) begin bad++; $display("FAIL bp_resume: got %0d bursts want >4", burst_cnt); end
        for (int i = 0; i < obs_adr.size(); i++) begin
            total++;
            if (obs_adr[i] !== 32'h0000_1000 + 32'(32 * i)) begin
                bad++; $display("FAIL bp_adr[%0d]: got %h want %h", i, obs_adr[i], 32'h0000_1000 + 32'(32 * i));
            end
        end
    endtask

    task automatic test_soft_reset();
        logic [15:0] e;
        bit found;
        int pv, sc;
        sb_clear();
        keep = 1'b0;
        baseaddress = 32'h2000_0018; nbursts = 19'd8; slave_lat = 3;
        pixel_ack = 1'b1; vga_rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge sys_clk); #1;
            if (fml_ack === 1'b1) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL srst_timeout: got no fml_ack want ack within 50 cycles"); end
        pv = (pixel_valid === 1'b1) ? 1 : 0;
        @(negedge sys_clk); #1;
        vga_rst = 1'b1;
        sc = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge sys_clk);
            if (pixel_valid === 1'b1) pv++;
            if (i >= 5 && fml_stb === 1'b1) sc++;
        end
        total++;
        if (pv != 0) begin bad++; $display("FAIL srst_valid: got %0d valid cycles want 0", pv); end
        total++;
        if (sc != 0) begin bad++; $display("FAIL srst_no_req: got %0d stb cycles want 0", sc); end
        total++;
        if (burst_cnt != 1) begin bad++; $display("FAIL srst_bursts: got %0d want 1", burst_cnt); end
        sb_clear();
        vga_rst = 1'b0;
        for (int i = 0; i < 50 && obs_adr.size() == 0; i++) @(negedge sys_clk);
        total++;
        if (obs_adr.size() == 0) begin
            bad++; $display("FAIL srst_restart: got no request want request within 50 cycles");
        end else begin
            total++;
            if (obs_adr[0] !== 32'h2000_0000) begin bad++; $display("FAIL srst_adr: got %h want 20000000", obs_adr[0]); end
            total++;
            if (obs_bak[0] !== 1'b1) begin bad++; $display("FAIL srst_bak: got %b want 1", obs_bak[0]); end
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (pixel_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL srst_pixel: got %h want nothing queued", pixel);
                end else begin
                    e = exp_q.pop_front();
                    if (pixel !== e) begin bad++; $display("FAIL srst_pixel: got %h want %h", pixel, e); end
                end
            end
        end
        quiesce();
    endtask

    task automatic test_async_reset();
        bit found;
        sb_clear();
        baseaddress = 32'h0000_8000; nbursts = 19'd50; slave_lat = 1;
        pixel_ack = 1'b0; vga_rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge sys_clk); #1;
            if (burst_cnt >= 1 && fml_stb === 1'b0) found = 1'b1;
        end
        slave_lat = 1000;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge sys_clk); #1;
            if (fml_stb === 1'b1 && pixel_valid === 1'b1) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL arst_setup: got stb=%b valid=%b want both 1", fml_stb, pixel_valid);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        total++; if (fml_stb !== 1'b0) begin bad++; $display("FAIL arst_stb: got %b want 0", fml_stb); end
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", pixel_valid); end
        total++; if (baseaddress_ack !== 1'b0) begin bad++; $display("FAIL arst_bak: got %b want 0", baseaddress_ack); end
        total++; if (fml_adr !== 32'h0) begin bad++; $display("FAIL arst_adr: got %h want 0", fml_adr); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        slave_lat = 1;
        quiesce();
    endtask

    task automatic test_nbursts_zero();
        int pv;
        sb_clear();
        nbursts = 19'd0; baseaddress = 32'h0000_4000;
        vga_rst = 1'b1; pixel_ack = 1'b0;
        @(negedge sys_clk);
        vga_rst = 1'b0; pixel_ack = 1'b1;
        pv = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (pixel_valid === 1'b1) pv++;
        end
        pixel_ack = 1'b0;
        @(negedge sys_clk);
        total++;
        if (burst_cnt != 0) begin bad++; $display("FAIL zero_bursts: got %0d want 0", burst_cnt); end
        total++;
        if (pv != 0) begin bad++; $display("FAIL zero_valid: got %0d valid cycles want 0", pv); end
`ifdef VGAFB_UNDERFLOW_CNT_EN
        total++;
        if (underflow_cnt !== 16'd10) begin bad++; $display("FAIL uflow_count: got %0d want 10", underflow_cnt); end
        vga_rst = 1'b1;
        @(negedge sys_clk);
        total++;
        if (underflow_cnt !== 16'd0) begin bad++; $display("FAIL uflow_clear: got %0d want 0", underflow_cnt); end
`endif
        quiesce();
    endtask

    initial begin
        test_reset();
        test_frame_fetch();
        test_pixel_order();
        test_back_to_back();
        test_soft_reset();
        test_async_reset();
        test_nbursts_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
